// File: rtl/counter_pkg.sv
// Shared constants for the modulus counter: run modes and one-shot states.
package counter_pkg;

  localparam logic [1:0] MODE_WRAP    = 2'b00;
  localparam logic [1:0] MODE_SAT     = 2'b01;
  localparam logic [1:0] MODE_ONESHOT = 2'b10;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_DONE = 1'b1
  } os_state_e;

endpackage

// File: rtl/prescale_tick_sefunmi.sv
// Enable prescaler: emits a one-cycle tick on every PRESCALE-th enabled cycle.
module prescale_tick_sefunmi #(
  parameter int PRESCALE = 1
) (
  input  logic clk_i,
  input  logic clear_i,
  input  logic restart_i,
  input  logic enable_i,
  output logic tick_o
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] cnt_q, cnt_d;

  assign tick_o = enable_i && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (restart_i) begin
      cnt_d = '0;
    end else if (enable_i) begin
      cnt_d = tick_o ? '0 : cnt_q + PW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (clear_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/counter_mod_sefunmi.sv
// Modulus counter with direction, load, prescaler and wrap/saturate/one-shot modes.
module counter_mod_sefunmi
  import counter_pkg::*;
#(
  parameter int WIDTH    = 9,
  parameter int PRESCALE = 1
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             enable,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             up,
  input  logic [WIDTH-1:0] limit,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             done
);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             tc_q, tc_d;
  os_state_e        st_q, st_d;
  logic             tick, freeze;
  logic             m_wrap, m_sat, m_os;
  logic [WIDTH:0]   inc;

  always_comb begin
    m_wrap = 1'b0;
    m_sat  = 1'b0;
    m_os   = 1'b0;
    unique case (1'b1)
      (mode == MODE_SAT):     m_sat  = 1'b1;
      (mode == MODE_ONESHOT): m_os   = 1'b1;
      default:                m_wrap = 1'b1;
    endcase
  end

  assign freeze = m_os && (st_q == ST_DONE);
  assign inc    = {1'b0, cnt_q} + (WIDTH+1)'(1);

  prescale_tick_sefunmi #(
    .PRESCALE (PRESCALE)
  ) u_pre (
    .clk_i     (clk),
    .clear_i   (clear),
    .restart_i (load),
    .enable_i  (enable && !freeze),
    .tick_o    (tick)
  );

  always_comb begin
    cnt_d = cnt_q;
    tc_d  = 1'b0;
    st_d  = m_os ? st_q : ST_RUN;
    if (load) begin
      cnt_d = (load_val > limit) ? limit : load_val;
      st_d  = ST_RUN;
    end else if (tick) begin
      if (limit == '0) begin
        cnt_d = '0;
        tc_d  = !m_sat;
      end else if (up) begin
        if (cnt_q >= limit) begin
          // covers a limit lowered below the current count
          cnt_d = m_wrap ? '0 : limit;
          tc_d  = m_wrap;
        end else begin
          cnt_d = inc[WIDTH-1:0];
          tc_d  = !m_wrap && (inc == {1'b0, limit});
        end
      end else begin
        if (cnt_q == '0) begin
          cnt_d = m_wrap ? limit : '0;
          tc_d  = m_wrap;
        end else begin
          cnt_d = cnt_q - WIDTH'(1);
          tc_d  = !m_wrap && (cnt_q == WIDTH'(1));
        end
      end
      if (m_os && tc_d) st_d = ST_DONE;
    end
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      cnt_q <= '0;
      tc_q  <= 1'b0;
      st_q  <= ST_RUN;
    end else begin
      cnt_q <= cnt_d;
      tc_q  <= tc_d;
      st_q  <= st_d;
    end
  end

  assign count = cnt_q;
  assign tc    = tc_q;
  assign done  = (st_q == ST_DONE);

endmodule

// File: tb/tb_counter_mod_sefunmi.sv
// Scoreboard bench: two instances (prescale 1 and 4) against a behavioural model.
module tb_counter_mod_sefunmi;

  localparam int W = 9;

  typedef struct {
    int cnt;
    bit tc;
    bit done;
    int pre;
  } m_t;

  logic         clk = 1'b0;
  logic         clear_r = 1'b1, load_r = 1'b0, en_r = 1'b0, up_r = 1'b1;
  logic [W-1:0] lv_r = '0, lim_r = '0;
  logic [1:0]   mode_r = '0;

  logic [W-1:0] cnt1, cnt4;
  logic         tc1, tc4, done1, done4;

  m_t m1, m4;
  m_t q1[$];
  m_t q4[$];
  int errors = 0;
  int checks = 0;
  int cycle = 0;
  bit stim_done = 0;

  always #5 clk = ~clk;

  counter_mod_sefunmi #(.WIDTH(W), .PRESCALE(1)) u_dut1 (
    .clk(clk), .clear(clear_r), .enable(en_r), .load(load_r),
    .load_val(lv_r), .up(up_r), .limit(lim_r), .mode(mode_r),
    .count(cnt1), .tc(tc1), .done(done1)
  );

  counter_mod_sefunmi #(.WIDTH(W), .PRESCALE(4)) u_dut4 (
    .clk(clk), .clear(clear_r), .enable(en_r), .load(load_r),
    .load_val(lv_r), .up(up_r), .limit(lim_r), .mode(mode_r),
    .count(cnt4), .tc(tc4), .done(done4)
  );

  // One counting step from the rules: mode 3 is wrap, limit 0 pins count at 0.
  function automatic m_t do_step(m_t s);
    m_t n = s;
    int md = (mode_r == 2'd3) ? 0 : int'(mode_r);
    int lim = int'(lim_r);
    if (lim == 0) begin
      n.cnt = 0;
      n.tc = (md != 1);
    end else if (up_r) begin
      if (s.cnt >= lim) begin
        n.cnt = (md == 0) ? 0 : lim;
        n.tc = (md == 0);
      end else begin
        n.cnt = s.cnt + 1;
        n.tc = (md != 0) && (n.cnt == lim);
      end
    end else begin
      if (s.cnt == 0) begin
        n.cnt = (md == 0) ? lim : 0;
        n.tc = (md == 0);
      end else begin
        n.cnt = s.cnt - 1;
        n.tc = (md != 0) && (n.cnt == 0);
      end
    end
    if (md == 2 && n.tc) n.done = 1;
    return n;
  endfunction

  function automatic m_t nxt(m_t s, int p);
    m_t n = s;
    bit frozen;
    n.tc = 0;
    if (clear_r) begin
      n.cnt = 0; n.done = 0; n.pre = 0;
    end else if (load_r) begin
      n.cnt = (lv_r > lim_r) ? int'(lim_r) : int'(lv_r);
      n.done = 0; n.pre = 0;
    end else begin
      frozen = s.done && (mode_r == 2'd2);
      if (mode_r != 2'd2) n.done = 0;
      if (en_r && !frozen) begin
        if (s.pre == p - 1) begin
          n.pre = 0;
          n = do_step(n);
        end else begin
          n.pre = s.pre + 1;
        end
      end
    end
    return n;
  endfunction

  task automatic cyc(bit c, bit l, int lv, bit u, int lim, int md,
                     bit e, int n = 1);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      clear_r = c; load_r = l; lv_r = W'(lv); up_r = u;
      lim_r = W'(lim); mode_r = 2'(md); en_r = e;
      m1 = nxt(m1, 1);
      m4 = nxt(m4, 4);
      q1.push_back(m1);
      q4.push_back(m4);
    end
  endtask

  task automatic cmp(int id, m_t e, logic [W-1:0] c, logic t, logic d);
    checks++;
    if (c !== W'(e.cnt) || t !== e.tc || d !== e.done) begin
      errors++;
      $display("FAIL dut%0d cycle %0d: count=%0d tc=%0b done=%0b, expected count=%0d tc=%0b done=%0b",
               id, cycle, c, t, d, e.cnt, e.tc, e.done);
    end
  endtask

  always @(posedge clk) begin
    #1;
    cycle++;
    if (q1.size() > 0) cmp(1, q1.pop_front(), cnt1, tc1, done1);
    if (q4.size() > 0) cmp(4, q4.pop_front(), cnt4, tc4, done4);
  end

  initial begin
    m1 = '{0, 0, 0, 0};
    m4 = '{0, 0, 0, 0};
    // reset held with enable, then long wrap-up run across 511
    cyc(1, 0, 0, 1, 511, 0, 1, 3);
    cyc(0, 0, 0, 1, 511, 0, 1, 520);
    // down wrap and down saturate
    cyc(0, 1, 2, 0, 5, 0, 0);
    cyc(0, 0, 0, 0, 5, 0, 1, 12);
    cyc(0, 1, 2, 0, 5, 1, 0);
    cyc(0, 0, 0, 0, 5, 1, 1, 12);
    // one-shot: finish, hold, reload, resume
    cyc(0, 1, 0, 1, 3, 2, 1);
    cyc(0, 0, 0, 1, 3, 2, 1, 35);
    cyc(0, 1, 0, 1, 3, 2, 1);
    cyc(0, 0, 0, 1, 3, 2, 1, 6);
    // leave one-shot while done, then limit==0 in each mode
    cyc(0, 0, 0, 1, 3, 2, 1, 12);
    cyc(0, 0, 0, 1, 3, 0, 1, 3);
    cyc(0, 0, 0, 1, 0, 0, 1, 4);
    cyc(0, 0, 0, 1, 0, 1, 1, 4);
    cyc(0, 0, 0, 0, 0, 2, 1, 8);
    // simultaneous events
    cyc(1, 1, 7, 1, 100, 0, 1);
    cyc(0, 1, 9, 1, 100, 0, 1);
    cyc(0, 1, 400, 1, 100, 0, 1);
    // runtime limit drop below count, wrap then saturate
    cyc(0, 1, 50, 1, 100, 0, 0);
    cyc(0, 0, 0, 1, 100, 0, 1, 4);
    cyc(0, 0, 0, 1, 20, 0, 1, 4);
    cyc(0, 1, 50, 1, 100, 1, 0);
    cyc(0, 0, 0, 1, 100, 1, 1, 4);
    cyc(0, 0, 0, 1, 20, 1, 1, 6);
    // randomized traffic with small limits to reach terminals often
    begin
      int lim = 6, md = 0;
      bit u = 1;
      for (int i = 0; i < 3000; i++) begin
        if ($urandom_range(0, 31) == 0) lim = $urandom_range(0, 9);
        if ($urandom_range(0, 63) == 0) lim = $urandom_range(0, 511);
        if ($urandom_range(0, 15) == 0) md = $urandom_range(0, 3);
        if ($urandom_range(0, 15) == 0) u = $urandom_range(0, 1);
        cyc($urandom_range(0, 199) == 0, $urandom_range(0, 39) == 0,
            $urandom_range(0, 12), u, lim, md, $urandom_range(0, 3) != 0);
      end
    end
    stim_done = 1;
    repeat (3) @(negedge clk);
    checks++;
    if (q1.size() != 0 || q4.size() != 0) begin
      errors++;
      $display("FAIL drain: pending=%0d, expected 0", q1.size() + q4.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
